// File: rtl/ama_riscv_pkg.sv
// Shared constants and types for the main-memory arbiter.
package ama_riscv_pkg;

    localparam int MEM_ADDR_BUS = 32;
    localparam int MEM_DATA_BUS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MREQ = 2'd1,
        MRSP = 2'd2
    } arb_state_t;

    // Index width for a channel count, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ama_riscv_mem_arb_if.sv
// Requester-side and memory-side bus bundle for ama_riscv_mem_arb.
interface ama_riscv_mem_arb_if
    import ama_riscv_pkg::*;
#(
    parameter int CH = 2,
    parameter int AW = MEM_ADDR_BUS,
    parameter int DW = MEM_DATA_BUS
);
    logic [CH-1:0]         req_valid;
    logic [CH-1:0]         req_ready;
    logic [CH-1:0][AW-1:0] req_addr;
    logic [CH-1:0]         req_we;
    logic [CH-1:0][DW-1:0] req_wdata;
    logic [CH-1:0]         rsp_valid;
    logic [CH-1:0]         rsp_ready;
    logic [DW-1:0]         rsp_data;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [AW-1:0]         mem_req_addr;
    logic                  mem_req_we;
    logic [DW-1:0]         mem_req_wdata;
    logic                  mem_rsp_valid;
    logic                  mem_rsp_ready;
    logic [DW-1:0]         mem_rsp_data;

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, rsp_valid, rsp_data,
               mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_rsp_ready
    );

    modport master (
        output req_valid, req_addr, req_we, req_wdata, rsp_ready,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, rsp_valid, rsp_data,
               mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_rsp_ready
    );

endinterface

// File: rtl/ama_riscv_rr_arb.sv
// Grant picker: cyclic search from ptr with AMA_RISCV_MEM_ARB_RR_EN,
// otherwise fixed priority (lowest index wins, ptr held at 0).
module ama_riscv_rr_arb
    import ama_riscv_pkg::*;
#(
    parameter int CH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         req_i,
    input  logic                  adv_i,
    output logic [CH-1:0]         gnt_o,
    output logic [idx_w(CH)-1:0]  gnt_idx_o
);
    localparam int IW = idx_w(CH);

    logic [IW-1:0] ptr;

`ifdef AMA_RISCV_MEM_ARB_RR_EN
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    always_comb begin
        ptr_d = (int'(gnt_idx_o) == CH - 1) ? '0 : gnt_idx_o + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)        ptr_q <= '0;
        else if (adv_i) ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst, adv_i};
    assign ptr = '0;
`endif

    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < CH; i++) begin
            idx = IW'((int'(ptr) + i) % CH);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/ama_riscv_mem_arb.sv
// CH-channel arbiter in front of the single-ported main memory; one
// transaction in flight. Round-robin under AMA_RISCV_MEM_ARB_RR_EN.
module ama_riscv_mem_arb
    import ama_riscv_pkg::*;
#(
    parameter int CH = 2,
    parameter int AW = MEM_ADDR_BUS,
    parameter int DW = MEM_DATA_BUS
) (
    input  logic               clk,
    input  logic               rst,
    ama_riscv_mem_arb_if.slave bus
);
    localparam int IW = idx_w(CH);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;

    logic [CH-1:0] gnt_oh;
    logic [IW-1:0] gnt_idx;
    logic          accept;

    ama_riscv_rr_arb #(.CH(CH)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.req_valid),
        .adv_i     (accept),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        state_d           = state_q;
        accept            = 1'b0;
        bus.req_ready     = '0;
        bus.rsp_valid     = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_rsp_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    bus.req_ready = gnt_oh;
                    if (|bus.req_valid) begin
                        accept  = 1'b1;
                        state_d = MREQ;
                    end
                end
                MREQ: begin
                    bus.mem_req_valid = 1'b1;
                    if (bus.mem_req_ready) state_d = we_q ? IDLE : MRSP;
                end
                MRSP: begin
                    // Zero-latency pass-through to the owning channel only.
                    bus.rsp_valid[owner_q] = bus.mem_rsp_valid;
                    bus.mem_rsp_ready      = bus.rsp_ready[owner_q];
                    if (bus.mem_rsp_valid && bus.rsp_ready[owner_q]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= gnt_idx;
                addr_q  <= bus.req_addr[gnt_idx];
                we_q    <= bus.req_we[gnt_idx];
                wdata_q <= bus.req_wdata[gnt_idx];
            end
        end
    end

    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_we    = we_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.rsp_data      = bus.mem_rsp_data;

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// Bench for ama_riscv_mem_arb: CH=2 instance with a memory responder and a
// CH=4 instance for priority tables; expectations follow AMA_RISCV_MEM_ARB_RR_EN.
module tb_ama_riscv_mem_arb;
    import ama_riscv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ama_riscv_mem_arb_if #(.CH(2)) bus2 ();
    ama_riscv_mem_arb_if #(.CH(4)) bus4 ();

    ama_riscv_mem_arb #(.CH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    ama_riscv_mem_arb #(.CH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory responder for bus2 ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } dreq_t;

    logic [31:0] mem [logic [31:0]];
    dreq_t       dlog[$];
    int          rsp_lat = 3;
    int          nrsp_x  = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    initial begin
        bit          rq, rs, rst_s, pend;
        int          cnt;
        logic [31:0] ra, rwd, rdat;
        logic        rw;
        pend = 0; cnt = 0; rdat = 0;
        bus2.mem_rsp_valid = 1'b0;
        bus2.mem_rsp_data  = 32'hA5A5_0F0F;
        forever begin
            @(negedge clk);
            rst_s = rst;
            rq  = bus2.mem_req_valid && bus2.mem_req_ready;
            ra  = bus2.mem_req_addr;
            rw  = bus2.mem_req_we;
            rwd = bus2.mem_req_wdata;
            rs  = bus2.mem_rsp_valid && bus2.mem_rsp_ready;
            @(posedge clk);
            #1;
            if (rst_s) begin
                pend = 0;
                bus2.mem_rsp_valid = 1'b0;
            end else begin
                if (rq) begin
                    dlog.push_back('{ra, rw, rwd});
                    if (rw) mem[ra] = rwd;
                    else begin pend = 1; cnt = rsp_lat; rdat = mem_rd(ra); end
                end
                if (rs) begin
                    nrsp_x++;
                    bus2.mem_rsp_valid = 1'b0;
                    bus2.mem_rsp_data  = $urandom;
                end
                if (pend) begin
                    cnt--;
                    if (cnt <= 0) begin
                        bus2.mem_rsp_valid = 1'b1;
                        bus2.mem_rsp_data  = rdat;
                        pend = 0;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic int pick(input logic [3:0] m, input int n, input int p);
        for (int k = 0; k < n; k++) begin
            if (m[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    task automatic wait_gnt2(input int ch, input string nm);
        bit g = 0;
        for (int n = 0; n < 50 && !g; n++) begin
            @(negedge clk);
            g = bus2.req_ready[ch];
            tick();
        end
        bus2.req_valid[ch] = 1'b0;
        check({nm, "_gnt"}, 64'(g), 64'd1);
    endtask

    task automatic rd2(input int ch, input logic [31:0] a, input logic [31:0] exp, input string nm);
        bit          r = 0, oth = 0;
        logic [31:0] d = '0;
        bus2.req_addr[ch]  = a;
        bus2.req_we[ch]    = 1'b0;
        bus2.rsp_ready[ch] = 1'b1;
        bus2.req_valid[ch] = 1'b1;
        wait_gnt2(ch, nm);
        for (int n = 0; n < 60 && !r; n++) begin
            @(negedge clk);
            oth = oth | bus2.rsp_valid[1-ch];
            if (bus2.rsp_valid[ch]) begin r = 1; d = bus2.rsp_data; end
            tick();
        end
        check({nm, "_rsp"}, 64'(r), 64'd1);
        check({nm, "_data"}, 64'(d), 64'(exp));
        check({nm, "_other_rsp"}, 64'(oth), 64'd0);
    endtask

    typedef struct {
        logic [3:0] mask;
        int         exp_g;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int          q[$];
        int          gc[2], rc[2];
        int          base, rbase, ok;
        bit          r;
        logic [3:0]  v4;
        logic [31:0] ref_mem [logic [31:0]];
        bit          pv[2], pw[2], stop;
        logic [31:0] pa[2], pd[2], oa, od, ex;
        bit          ow;
        int          phase, own, mptr, g;
        logic [1:0]  expm;

`ifdef AMA_RISCV_MEM_ARB_RR_EN
        int exp_cont[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        int exp_wrap[4] = '{3, 0, 1, 2};
        tbl = '{'{4'h1, 0}, '{4'h1, 0}, '{4'hF, 1}, '{4'h3, 0}, '{4'hA, 1},
                '{4'h4, 2}, '{4'hF, 3}, '{4'hE, 1}, '{4'h9, 3}, '{4'hC, 2}};
`else
        int exp_cont[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        int exp_wrap[4] = '{0, 1, 2, 3};
        tbl = '{'{4'h1, 0}, '{4'h1, 0}, '{4'hF, 0}, '{4'h3, 0}, '{4'hA, 1},
                '{4'h4, 2}, '{4'hF, 0}, '{4'hE, 1}, '{4'h9, 0}, '{4'hC, 2}};
`endif

        bus2.req_valid = 2'b11; bus2.req_addr = '0; bus2.req_we = '0;
        bus2.req_wdata = '0;    bus2.rsp_ready = 2'b11; bus2.mem_req_ready = 1'b1;
        bus4.req_valid = '0;    bus4.req_addr = '0; bus4.req_we = 4'hF;
        bus4.req_wdata = '0;    bus4.rsp_ready = 4'hF;  bus4.mem_req_ready = 1'b1;
        bus4.mem_rsp_valid = 1'b0; bus4.mem_rsp_data = '0;

        // ---- reset state ----
        tick(); tick();
        @(negedge clk);
        check("rst_req_ready", 64'(bus2.req_ready), 64'd0);
        check("rst_mem_req_valid", 64'(bus2.mem_req_valid), 64'd0);
        check("rst_mem_rsp_ready", 64'(bus2.mem_rsp_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus2.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus2.rsp_data), 64'hA5A5_0F0F);
        check("rst_state", 64'(dut2.state_q), 64'(IDLE));
        check("rst_payload", {dut2.addr_q, dut2.wdata_q}, 64'd0);
        check("rst_we_owner", {dut2.we_q, dut2.owner_q}, 64'd0);
        tick();
        bus2.req_valid = '0;
        rst = 1'b0;
        tick();

        // ---- single read ----
        mem[32'h40] = 32'hDEAD_BEEF;
        rsp_lat = 3;
        rd2(1, 32'h40, 32'hDEAD_BEEF, "single_rd");

        // ---- contention: 4 reads per channel ----
        mem[32'h100] = 32'hC0C0_0000;
        mem[32'h200] = 32'hC1C1_0001;
        rsp_lat = 1;
        bus2.req_addr[0] = 32'h100; bus2.req_addr[1] = 32'h200;
        bus2.req_we = '0; bus2.rsp_ready = 2'b11; bus2.req_valid = 2'b11;
        gc = '{0, 0}; rc = '{0, 0}; ok = 1;
        for (int n = 0; n < 400 && (rc[0] < 4 || rc[1] < 4); n++) begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (bus2.req_ready[c]) begin q.push_back(c); gc[c]++; end
                if (bus2.rsp_valid[c]) begin
                    rc[c]++;
                    if (bus2.rsp_data !== (c == 0 ? 32'hC0C0_0000 : 32'hC1C1_0001)) ok = 0;
                end
            end
            tick();
            for (int c = 0; c < 2; c++) bus2.req_valid[c] = (gc[c] < 4);
        end
        bus2.req_valid = '0;
        check("cont_count", 64'(q.size()), 64'd8);
        check("cont_data", 64'(ok), 64'd1);
        for (int i = 0; i < 8 && i < q.size(); i++)
            check($sformatf("cont_order%0d", i), 64'(q[i]), 64'(exp_cont[i]));
        q.delete();

        // ---- write then read back ----
        base = dlog.size();
        bus2.req_addr[0] = 32'h80; bus2.req_we[0] = 1'b1;
        bus2.req_wdata[0] = 32'h1234_5678; bus2.req_valid[0] = 1'b1;
        wait_gnt2(0, "wr");
        @(negedge clk);
        check("wr_mreq", {bus2.mem_req_valid, bus2.mem_req_we}, 64'h3);
        tick();
        @(negedge clk);
        check("wr_idle_after", 64'(dut2.state_q), 64'(IDLE));
        check("wr_one_xfer", 64'(dlog.size() - base), 64'd1);
        if (dlog.size() > base)
            check("wr_payload", {dlog[base].addr, dlog[base].wdata}, {32'h80, 32'h1234_5678});
        check("wr_no_rsp", 64'(bus2.rsp_valid), 64'd0);
        tick();
        bus2.req_we[0] = 1'b0;
        rd2(0, 32'h80, 32'h1234_5678, "wr_readback");

        // ---- backpressure ----
        mem[32'h44] = 32'hB0B0_4444;
        rsp_lat = 2;
        bus2.mem_req_ready = 1'b0;
        bus2.req_addr[1] = 32'h44; bus2.req_we[1] = 1'b0;
        bus2.rsp_ready[1] = 1'b0; bus2.req_valid[1] = 1'b1;
        wait_gnt2(1, "bp");
        bus2.req_addr[0] = 32'h300; bus2.req_we[0] = 1'b0; bus2.req_valid[0] = 1'b1;
        base = dlog.size(); rbase = nrsp_x; ok = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus2.mem_req_valid && bus2.mem_req_addr == 32'h44 && !bus2.mem_req_we &&
                bus2.req_ready == 2'b00) ok++;
            tick();
        end
        check("bp_mreq_hold", 64'(ok), 64'd5);
        bus2.mem_req_ready = 1'b1;
        r = 0;
        for (int n = 0; n < 30 && !r; n++) begin
            @(negedge clk);
            r = bus2.rsp_valid[1];
            tick();
        end
        check("bp_rsp_seen", 64'(r), 64'd1);
        ok = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (bus2.rsp_valid == 2'b10 && !bus2.mem_rsp_ready &&
                bus2.rsp_data == 32'hB0B0_4444 && bus2.req_ready == 2'b00) ok++;
            tick();
        end
        check("bp_rsp_hold", 64'(ok), 64'd4);
        bus2.req_valid[0] = 1'b0;
        bus2.rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("bp_rsp_xfer", {bus2.rsp_valid[1], bus2.mem_rsp_ready}, 64'h3);
        tick(); tick(); tick();
        check("bp_one_mreq", 64'(dlog.size() - base), 64'd1);
        check("bp_one_rsp", 64'(nrsp_x - rbase), 64'd1);

        // ---- reset mid-read ----
        rsp_lat = 10;
        bus2.req_addr[0] = 32'h40; bus2.req_valid[0] = 1'b1; bus2.rsp_ready = 2'b11;
        wait_gnt2(0, "mid_rst");
        tick();
        @(negedge clk);
        check("mid_rst_in_mrsp", 64'(dut2.state_q), 64'(MRSP));
`ifdef AMA_RISCV_MEM_ARB_RR_EN
        check("mid_rst_ptr_pre", 64'(dut2.u_arb.ptr_q), 64'd1);
`endif
        tick();
        rst = 1'b1;
        bus2.req_addr[1] = 32'h40; bus2.req_valid[1] = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_low", 64'(bus2.req_ready), 64'd0);
        tick();
        rst = 1'b0;
        bus2.req_valid[1] = 1'b0;
        @(negedge clk);
        check("mid_rst_state", 64'(dut2.state_q), 64'(IDLE));
        check("mid_rst_regs", {dut2.owner_q, dut2.we_q, dut2.addr_q}, 64'd0);
        check("mid_rst_outs", {bus2.mem_req_valid, bus2.mem_rsp_ready, bus2.rsp_valid}, 64'd0);
`ifdef AMA_RISCV_MEM_ARB_RR_EN
        check("mid_rst_ptr", 64'(dut2.u_arb.ptr_q), 64'd0);
`endif
        tick();
        rsp_lat = 3;
        rd2(1, 32'h40, 32'hDEAD_BEEF, "post_rst_rd");

        // ---- randomized traffic vs transaction-level model ----
        pv = '{0, 0}; pw = '{0, 0}; pa = '{0, 0}; pd = '{0, 0};
        phase = 0; own = 0; mptr = 0; stop = 0; oa = 0; od = 0; ow = 0; ex = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n >= 1500) stop = 1;
            if (stop && phase == 0 && !pv[0] && !pv[1]) break;
            tick();
            for (int c = 0; c < 2; c++) begin
                if (pv[c] && $urandom_range(15) == 0) pv[c] = 0;
                else if (!pv[c] && !stop && $urandom_range(2) == 0) begin
                    pv[c] = 1;
                    pa[c] = 32'h1000 + 32'($urandom_range(3)) * 4;
                    pw[c] = 1'($urandom_range(1));
                    pd[c] = $urandom;
                end
                bus2.req_valid[c] = pv[c];
                bus2.req_addr[c]  = pa[c];
                bus2.req_we[c]    = pw[c];
                bus2.req_wdata[c] = pd[c];
                bus2.rsp_ready[c] = ($urandom_range(3) != 0);
            end
            bus2.mem_req_ready = ($urandom_range(9) < 7);
            rsp_lat = $urandom_range(1, 4);
            @(negedge clk);
            g = (phase == 0) ? pick({2'b00, pv[1], pv[0]}, 2, mptr) : -1;
            expm = (g >= 0) ? 2'(2'b01 << g) : 2'b00;
            check("rand_gnt", 64'(bus2.req_ready), 64'(expm));
            check("rand_mreq_v", 64'(bus2.mem_req_valid), 64'(phase == 1));
            if (phase == 2)
                check("rand_rsp_v", 64'(bus2.rsp_valid),
                      64'(bus2.mem_rsp_valid ? 2'(2'b01 << own) : 2'b00));
            else
                check("rand_rsp_v0", 64'(bus2.rsp_valid), 64'd0);
            if (g >= 0) begin
                own = g; oa = pa[g]; ow = pw[g]; od = pd[g]; pv[g] = 0; phase = 1;
`ifdef AMA_RISCV_MEM_ARB_RR_EN
                mptr = (g + 1) % 2;
`endif
            end else if (phase == 1 && bus2.mem_req_ready) begin
                check("rand_mreq_addr_we", {bus2.mem_req_addr, bus2.mem_req_we}, {oa, ow});
                if (ow) begin
                    check("rand_mreq_wdata", 64'(bus2.mem_req_wdata), 64'(od));
                    ref_mem[oa] = od;
                    phase = 0;
                end else begin
                    ex = ref_mem.exists(oa) ? ref_mem[oa] : 32'h0;
                    phase = 2;
                end
            end else if (phase == 2 && bus2.mem_rsp_valid && bus2.rsp_ready[own]) begin
                check("rand_rsp_data", 64'(bus2.rsp_data), 64'(ex));
                phase = 0;
            end
        end
        check("rand_drain", 64'(phase), 64'd0);
        tick();
        bus2.req_valid = '0;

        // ---- CH=4 priority table ----
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < 4; c++) bus4.req_addr[c] = 32'(c * 32'h40 + i * 4);
            bus4.req_valid = tbl[i].mask;
            @(negedge clk);
            check($sformatf("tbl%0d_gnt", i), 64'(bus4.req_ready), 64'(4'(4'b0001 << tbl[i].exp_g)));
            tick();
            bus4.req_valid = '0;
            @(negedge clk);
            check($sformatf("tbl%0d_mreq", i), {bus4.mem_req_valid, bus4.mem_req_addr},
                  {1'b1, 32'(tbl[i].exp_g * 32'h40 + i * 4)});
            tick();
        end

        // ---- CH=4 wrap with all channels requesting ----
        v4 = 4'hF;
        bus4.req_valid = v4;
        for (int n = 0; n < 40 && q.size() < 4; n++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) if (bus4.req_ready[c]) begin q.push_back(c); v4[c] = 1'b0; end
            tick();
            bus4.req_valid = v4;
        end
        check("wrap_count", 64'(q.size()), 64'd4);
        for (int i = 0; i < 4 && i < q.size(); i++)
            check($sformatf("wrap_order%0d", i), 64'(q[i]), 64'(exp_wrap[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
